// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core.
// Decodes the IR opcode, sequences instruction steps, drives datapath
// enables/selects and the aluop/funct-source pair consumed by the ALU decoder,
// and stretches FETCH/MEMRD/MEMWR while memory is not ready.
// Optional feature: define MIPS_ILLEGAL_OP_TRAP_EN to trap unknown opcodes
// in TRAP (illegal=1 until reset); otherwise unknown opcodes are skipped.
module mips_multicycle_ctrl #(
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   opcode,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              iord,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic              imm_zext,
    output logic [1:0]        pc_src,
    output logic [1:0]        aluop,
    output logic              alu_funct_src,
    output logic              illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JEX     = 4'd11,
        LOGIEX  = 4'd12,
        TRAP    = 4'd13
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    state_t state_q;
    state_t state_n;

    assign state = state_q;

    // State register; reset aborts any instruction in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state sequencing, including memory wait states.
    always_comb begin
        state_n = state_q;
        case (state_q)
            FETCH:   state_n = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:    state_n = MEMADR;
                    OP_RTYPE:        state_n = RTYPEEX;
                    OP_BEQ:          state_n = BEQEX;
                    OP_ADDI:         state_n = IMMEX;
                    OP_ANDI, OP_ORI: state_n = LOGIEX;
                    OP_J:            state_n = JEX;
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
                    default:         state_n = TRAP;
`else
                    default:         state_n = FETCH;
`endif
                endcase
            end
            MEMADR:  state_n = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_n = mem_ready ? MEMWB : MEMRD;
            MEMWB:   state_n = FETCH;
            MEMWR:   state_n = mem_ready ? FETCH : MEMWR;
            RTYPEEX: state_n = RTYPEWB;
            RTYPEWB: state_n = FETCH;
            BEQEX:   state_n = FETCH;
            IMMEX:   state_n = IMMWB;
            LOGIEX:  state_n = IMMWB;
            IMMWB:   state_n = FETCH;
            JEX:     state_n = FETCH;
            TRAP:    state_n = TRAP;
            default: state_n = FETCH;
        endcase
    end

    // Moore output decode; pc_en/ir_write also gated by mem_ready/zero, all forced low in reset.
    always_comb begin
        pc_en         = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = '0;
        imm_zext      = 1'b0;
        pc_src        = '0;
        aluop         = '0;
        alu_funct_src = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_en     = mem_ready;
                ir_write  = mem_ready;
            end
            DECODE:  alu_src_b = 2'b11;
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            RTYPEEX: begin
                alu_src_a = 1'b1;
                aluop     = 2'b10;
            end
            RTYPEWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                aluop     = 2'b10;
            end
            BEQEX: begin
                alu_src_a = 1'b1;
                aluop     = 2'b01;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            LOGIEX: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b10;
                imm_zext      = 1'b1;
                aluop         = 2'b11;
                alu_funct_src = 1'b1;
            end
            IMMWB:   reg_write = 1'b1;
            JEX: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
            TRAP:    illegal = 1'b1;
`endif
            default: ;
        endcase
        if (reset) begin
            pc_en         = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = '0;
            imm_zext      = 1'b0;
            pc_src        = '0;
            aluop         = '0;
            alu_funct_src = 1'b0;
            illegal       = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: an instruction-level model
// (each opcode expands to a list of steps after DECODE) is checked against the
// DUT every cycle, plus directed scenarios with literal expectations.
module tb_mips_multicycle_ctrl;

    localparam bit TRAP_EN =
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct packed {
        logic       pc_en, iord, mem_read, mem_write, ir_write;
        logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zext;
        logic [1:0] pc_src;
        logic [1:0] aluop;
        logic       alu_funct_src, illegal;
    } ctl_t;

    typedef int plan_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a, imm_zext, alu_funct_src, illegal;
    logic [1:0] alu_src_b, pc_src, aluop;
    logic [3:0] state;

    int tests_run = 0;
    int tests_failed = 0;
    bit chk_en = 1'b0;

    int    m_state = 0;
    plan_t m_plan;
    ctl_t  exp_c, act_c;

    mips_multicycle_ctrl #(.OP_W(6), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_zext(imm_zext), .pc_src(pc_src), .aluop(aluop),
        .alu_funct_src(alu_funct_src), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Steps an instruction walks through after DECODE; empty means unknown opcode.
    function automatic plan_t plan_for(input logic [5:0] op);
        plan_t p;
        case (op)
            6'b100011: p = {2, 3, 4};
            6'b101011: p = {2, 5};
            6'b000000: p = {6, 7};
            6'b000100: p = {8};
            6'b001000: p = {9, 10};
            6'b001100: p = {12, 10};
            6'b001101: p = {12, 10};
            6'b000010: p = {11};
            default:   p = {};
        endcase
        return p;
    endfunction

    // Output table for each step as described for the controller.
    function automatic ctl_t exp_out(input int st, input logic mr, input logic z, input logic rst);
        ctl_t c;
        c = '0;
        if (rst) return c;
        case (st)
            0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.pc_en = mr; c.ir_write = mr; end
            1:  c.alu_src_b = 2'b11;
            2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            3:  begin c.iord = 1; c.mem_read = 1; end
            4:  begin c.mem_to_reg = 1; c.reg_write = 1; end
            5:  begin c.iord = 1; c.mem_write = 1; end
            6:  begin c.alu_src_a = 1; c.aluop = 2'b10; end
            7:  begin c.reg_dst = 1; c.reg_write = 1; c.aluop = 2'b10; end
            8:  begin c.alu_src_a = 1; c.aluop = 2'b01; c.pc_src = 2'b01; c.pc_en = z; end
            9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            10: c.reg_write = 1;
            11: begin c.pc_src = 2'b10; c.pc_en = 1; end
            12: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.imm_zext = 1;
                      c.aluop = 2'b11; c.alu_funct_src = 1; end
            13: c.illegal = 1;
            default: ;
        endcase
        return c;
    endfunction

    // Model advances one step per clock using the inputs held during the cycle.
    always @(posedge clk) begin
        int nxt;
        nxt = m_state;
        if (reset) begin
            nxt = 0;
            m_plan.delete();
        end else if (m_state == 13) begin
            nxt = 13;
        end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
            nxt = m_state;
        end else if (m_state == 0) begin
            nxt = 1;
        end else if (m_state == 1) begin
            m_plan = plan_for(opcode);
            if (m_plan.size() == 0) nxt = TRAP_EN ? 13 : 0;
            else nxt = m_plan.pop_front();
        end else if (m_plan.size() != 0) begin
            nxt = m_plan.pop_front();
        end else begin
            nxt = 0;
        end
        m_state <= nxt;
    end

    // Per-cycle comparison of all outputs and state against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_c = exp_out(m_state, mem_ready, zero, reset);
            act_c = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                     reg_write, alu_src_a, alu_src_b, imm_zext, pc_src, aluop,
                     alu_funct_src, illegal};
            tests_run++;
            if (act_c !== exp_c || state !== 4'(m_state)) begin
                tests_failed++;
                $display("FAIL cycle_cmp t=%0t: state=%0d outs=%h, expected state=%0d outs=%h",
                         $time, state, act_c, m_state, exp_c);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [5:0] op, input logic mr,
                       input logic z, input int es, input string tag);
        @(posedge clk);
        #1;
        reset = r; opcode = op; mem_ready = mr; zero = z;
        @(negedge clk);
        if (es >= 0) chk({tag, "_state"}, int'(state), es);
    endtask

    initial begin
        // reset held for two cycles
        @(posedge clk);
        #1 chk_en = 1'b1;
        cyc(1, 6'b000000, 1, 0, 0, "rst");
        chk("rst_mem_read", int'(mem_read), 0);
        chk("rst_pc_en", int'(pc_en), 0);
        chk("rst_alu_src_b", int'(alu_src_b), 0);

        // R-type: 0,1,6,7,0
        cyc(0, 6'b000000, 1, 0, 0, "r0");
        chk("r0_pc_en", int'(pc_en), 1);
        cyc(0, 6'b000000, 1, 0, 1, "r1");
        cyc(0, 6'b000000, 1, 0, 6, "r6");
        chk("r6_aluop", int'(aluop), 2);
        chk("r6_reg_write", int'(reg_write), 0);
        cyc(0, 6'b000000, 1, 0, 7, "r7");
        chk("r7_aluop", int'(aluop), 2);
        chk("r7_reg_write", int'(reg_write), 1);
        cyc(0, 6'b000000, 0, 0, 0, "r_end");

        // lw with two MEMRD wait cycles: 0,1,2,3,3,3,4,0
        cyc(0, 6'b100011, 1, 0, 0, "lw0");
        cyc(0, 6'b100011, 1, 0, 1, "lw1");
        cyc(0, 6'b100011, 1, 0, 2, "lw2");
        for (int i = 0; i < 3; i++) begin
            cyc(0, 6'b100011, (i == 2) ? 1'b1 : 1'b0, 0, 3, "lw3");
            chk("lw3_mem_read", int'(mem_read), 1);
            chk("lw3_iord", int'(iord), 1);
        end
        cyc(0, 6'b100011, 1, 0, 4, "lw4");
        chk("lw4_mem_to_reg", int'(mem_to_reg), 1);
        cyc(0, 6'b100011, 0, 0, 0, "lw_end");

        // beq taken / not taken
        for (int t = 1; t >= 0; t--) begin
            cyc(0, 6'b000100, 1, 1'(t), 0, "beq0");
            cyc(0, 6'b000100, 1, 1'(t), 1, "beq1");
            cyc(0, 6'b000100, 1, 1'(t), 8, "beq8");
            chk("beq_pc_en", int'(pc_en), t);
            chk("beq_pc_src", int'(pc_src), 1);
            cyc(0, 6'b000100, 0, 1'(t), 0, "beq_end");
        end

        // ori: 0,1,12,10,0
        cyc(0, 6'b001101, 1, 0, 0, "ori0");
        cyc(0, 6'b001101, 1, 0, 1, "ori1");
        cyc(0, 6'b001101, 1, 0, 12, "ori12");
        chk("ori_aluop", int'(aluop), 3);
        chk("ori_funct_src", int'(alu_funct_src), 1);
        chk("ori_imm_zext", int'(imm_zext), 1);
        cyc(0, 6'b001101, 1, 0, 10, "ori10");
        chk("ori_reg_write", int'(reg_write), 1);
        chk("ori_reg_dst", int'(reg_dst), 0);
        cyc(0, 6'b001101, 0, 0, 0, "ori_end");

        // unknown opcode
        cyc(0, 6'b111111, 1, 0, 0, "ill0");
        cyc(0, 6'b111111, 1, 0, 1, "ill1");
        if (TRAP_EN) begin
            cyc(0, 6'b111111, 1, 0, 13, "ill13a");
            chk("ill_illegal", int'(illegal), 1);
            cyc(0, 6'b111111, 1, 0, 13, "ill13b");
            chk("ill_hold", int'(illegal), 1);
            cyc(1, 6'b111111, 1, 0, 13, "ill_rst");
            cyc(0, 6'b111111, 0, 0, 0, "ill_end");
        end else begin
            cyc(0, 6'b111111, 0, 0, 0, "ill_skip");
            chk("ill_illegal", int'(illegal), 0);
        end

        // reset during MEMWR
        cyc(0, 6'b101011, 1, 0, 0, "sw0");
        cyc(0, 6'b101011, 1, 0, 1, "sw1");
        cyc(0, 6'b101011, 1, 0, 2, "sw2");
        cyc(0, 6'b101011, 0, 0, 5, "sw5");
        chk("sw5_mem_write", int'(mem_write), 1);
        cyc(1, 6'b101011, 0, 0, 5, "sw_rst");
        chk("sw_rst_mem_write", int'(mem_write), 0);
        cyc(0, 6'b101011, 0, 0, 0, "sw_after");

        // randomized instruction stream
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] legal [8];
            int pick;
            legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                      6'b001000, 6'b001100, 6'b001101, 6'b000010};
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 99) < ((m_state == 13) ? 30 : 2));
            if (m_state == 0 || reset) begin
                pick = int'($urandom_range(0, 9));
                opcode = (pick < 8) ? legal[pick] : 6'($urandom);
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            zero = 1'($urandom);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
